// File: rtl/oled_pkg.sv
// oled_pkg -- definitions shared by the SSD1306 SPI transmitter and its controller.
//   OLED_CMD / OLED_DAT : values of the D/C# qualifier (0 = command, 1 = data)
//   tx_state_t + ST_*   : transmitter FSM state type and encodings
//   spi_half_period()   : SCLK half-period in system clock cycles
package oled_pkg;

  localparam logic OLED_CMD = 1'b0;
  localparam logic OLED_DAT = 1'b1;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t ST_IDLE  = 3'd0;
  localparam tx_state_t ST_SETUP = 3'd1;
  localparam tx_state_t ST_SHIFT = 3'd2;
  localparam tx_state_t ST_HOLD  = 3'd3;
  localparam tx_state_t ST_GAP   = 3'd4;

  // clk_mhz * 1000 / (2 * spi_khz), integer-truncated.
  function automatic int unsigned spi_half_period(input int unsigned clk_mhz,
                                                  input int unsigned spi_khz);
    return (clk_mhz * 1000) / (2 * spi_khz);
  endfunction

endpackage

// File: rtl/oled_spi_tx_if.sv
// oled_spi_tx_if -- byte request handshake between the OLED controller and
// the SPI transmitter.
//   send_en   : byte request, level-sampled while the transmitter is idle
//   send_dc   : 0 = command, 1 = data
//   send_data : byte to transmit, MSB first
//   send_busy : high while a transfer is in progress
// modport master = controller side, modport slave = transmitter side.
interface oled_spi_tx_if;
  logic       send_en;
  logic       send_dc;
  logic [7:0] send_data;
  logic       send_busy;

  modport master (output send_en, output send_dc, output send_data, input send_busy);
  modport slave  (input send_en, input send_dc, input send_data, output send_busy);
endinterface

// File: rtl/oled_spi_clkdiv.sv
// oled_spi_clkdiv -- half-period tick generator for the SPI transmitter.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   clr_i  : hold the counter at zero (transmitter idle)
//   tick_o : single-cycle pulse on the last cycle of every HALF-cycle window
// Releasing clr_i starts a window on the following cycle, so every FSM phase
// lasts exactly HALF cycles measured from the accepting edge.
module oled_spi_clkdiv #(
  parameter int unsigned HALF = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last   = (cnt_q == CW'(HALF - 1));
  assign tick_o = last && !clr_i;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || last) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/oled_spi_tx.sv
// oled_spi_tx -- SSD1306 SPI byte transmitter (mode 0, MSB first).
//   clk, rst    : system clock, synchronous active-high reset
//   state_rst   : panel reset request (0 = panel held in reset)
//   tx (slave)  : send_en / send_dc / send_data request, send_busy status
//   oled_sclk, oled_mosi, oled_cs_n, oled_dc : 4-wire SPI pins
//   oled_res    : panel reset pin, state_rst delayed by one cycle
// Frame: SETUP (H) + N bits x 2H + HOLD (H) + GAP (H), H = SCLK half period.
// Build option OLED_SPI_3WIRE_EN: 3-wire mode, the D/C bit is shifted out
// ahead of the byte (N = 9) and oled_dc is held low.
module oled_spi_tx
  import oled_pkg::*;
#(
  parameter int unsigned CLK_FRE = 50,
  parameter int unsigned SPI_KHZ = 5000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         state_rst,
  oled_spi_tx_if.slave tx,
  output logic         oled_sclk,
  output logic         oled_mosi,
  output logic         oled_cs_n,
  output logic         oled_dc,
  output logic         oled_res
);

  localparam int unsigned HALF = spi_half_period(CLK_FRE, SPI_KHZ);

`ifdef OLED_SPI_3WIRE_EN
  localparam int unsigned NBITS = 9;
`else
  localparam int unsigned NBITS = 8;
`endif
  localparam int unsigned BW = $clog2(NBITS);

  if (HALF < 2) begin : g_half_chk
    $error("oled_spi_tx: SCLK half period must be at least 2 clk cycles");
  end

  tx_state_t        state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             high_q, high_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;
  logic             dc_q, dc_d;
  logic             busy_q, busy_d;
  logic             res_q;
  logic             tick;

  oled_spi_clkdiv #(
    .HALF (HALF)
  ) u_clkdiv (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == ST_IDLE),
    .tick_o (tick)
  );

  // Pins are registered from next-state values so they change on the same
  // edge as the FSM and stay glitch-free.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    high_d  = high_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    dc_d    = dc_q;
    busy_d  = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (tx.send_en) begin
`ifdef OLED_SPI_3WIRE_EN
          shreg_d = {tx.send_dc, tx.send_data};
          dc_d    = OLED_CMD;
`else
          shreg_d = tx.send_data;
          dc_d    = tx.send_dc;
`endif
          mosi_d  = shreg_d[NBITS-1];
          bit_d   = '0;
          high_d  = 1'b0;
          sclk_d  = 1'b0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (tick) begin
          high_d  = 1'b0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          if (!high_q) begin
            high_d = 1'b1;
            sclk_d = 1'b1;
          end else begin
            // Falling edge: the only point where MOSI may move.
            high_d = 1'b0;
            sclk_d = 1'b0;
            if (bit_q == BW'(NBITS - 1)) begin
              state_d = ST_HOLD;
            end else begin
              bit_d   = bit_q + 1'b1;
              shreg_d = shreg_q << 1;
              mosi_d  = shreg_q[NBITS-2];
            end
          end
        end
      end

      ST_HOLD: begin
        if (tick) begin
          cs_n_d  = 1'b1;
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        if (tick) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        sclk_d  = 1'b0;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      high_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      dc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      high_q  <= high_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      dc_q    <= dc_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= 1'b0;
    end else begin
      res_q <= state_rst;
    end
  end

  assign tx.send_busy = busy_q;
  assign oled_sclk    = sclk_q;
  assign oled_mosi    = mosi_q;
  assign oled_cs_n    = cs_n_q;
  assign oled_dc      = dc_q;
  assign oled_res     = res_q;

endmodule

// File: tb/tb_oled_spi_tx.sv
// tb_oled_spi_tx -- self-checking bench for oled_spi_tx (CLK_FRE=50,
// SPI_KHZ=5000, so H=5). Each transfer is checked against a slave-side view:
// bits captured on rising SCLK, D/C while CS is low, busy length and pulses.
module tb_oled_spi_tx;

  localparam int H = (50 * 1000) / (2 * 5000);
`ifdef OLED_SPI_3WIRE_EN
  localparam int  NB    = 9;
  localparam bit  THREE = 1'b1;
`else
  localparam int  NB    = 8;
  localparam bit  THREE = 1'b0;
`endif
  localparam int BUSY_LEN = H * (2 * NB + 3);
  localparam int LIMIT    = 1000;

  logic clk = 1'b0;
  logic rst;
  logic state_rst;
  logic oled_sclk, oled_mosi, oled_cs_n, oled_dc, oled_res;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;

  oled_spi_tx_if txif ();

  oled_spi_tx #(
    .CLK_FRE (50),
    .SPI_KHZ (5000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .state_rst (state_rst),
    .tx        (txif),
    .oled_sclk (oled_sclk),
    .oled_mosi (oled_mosi),
    .oled_cs_n (oled_cs_n),
    .oled_dc   (oled_dc),
    .oled_res  (oled_res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer. send_en is held for 'hold' cycles counted from the
  // accepting edge and pulsed again at cycle 'pulse_at' (negative = never).
  task automatic xfer(input logic dc, input logic [7:0] data,
                      input int hold, input int pulse_at);
    logic        exp_q[$];
    logic [15:0] exp_v, got_v;
    int          got_n, busy_n, rises, cs_rises, k;
    logic        prev_sclk, prev_cs, dc_ok, exp_dc;

    exp_q.delete();
    if (THREE) exp_q.push_back(dc);
    for (int i = 7; i >= 0; i--) exp_q.push_back(data[i]);
    exp_v = '0;
    foreach (exp_q[i]) exp_v = {exp_v[14:0], exp_q[i]};
    exp_dc = THREE ? 1'b0 : dc;

    got_v = '0; got_n = 0; busy_n = 0; rises = 0; cs_rises = 0; dc_ok = 1'b1;

    txif.send_en   = 1'b1;
    txif.send_dc   = dc;
    txif.send_data = data;
    prev_sclk = oled_sclk;
    prev_cs   = oled_cs_n;
    step();
    k = 1;
    chk("busy_rise", txif.send_busy, 1);
    chk("cs_fall", oled_cs_n, 0);

    while (txif.send_busy === 1'b1 && k < LIMIT) begin
      txif.send_en = (k < hold) || (k == pulse_at);
      if (oled_sclk && !prev_sclk) begin
        got_v = {got_v[14:0], oled_mosi};
        got_n++;
        rises++;
      end
      if (!oled_cs_n && oled_dc !== exp_dc) dc_ok = 1'b0;
      if (oled_cs_n && !prev_cs) cs_rises++;
      busy_n++;
      prev_sclk = oled_sclk;
      prev_cs   = oled_cs_n;
      step();
      k++;
    end
    txif.send_en = 1'b0;

    chk("busy_timeout", txif.send_busy, 0);
    chk("busy_len", busy_n, BUSY_LEN);
    chk("sclk_pulses", rises, NB);
    chk("bit_count", got_n, exp_q.size());
    chk("mosi_bits", got_v, exp_v);
    chk("dc_during_cs", dc_ok, 1);
    chk("cs_rises", cs_rises, 1);
    chk("cs_idle", oled_cs_n, 1);
    xfers++;
  endtask

  initial begin
    int rises;
    logic prev_sclk;
    logic [7:0] d;
    logic       c;

    rst = 1'b1;
    state_rst = 1'b1;
    txif.send_en = 1'b0;
    txif.send_dc = 1'b0;
    txif.send_data = '0;

    // Reset state
    repeat (3) step();
    chk("rst_sclk", oled_sclk, 0);
    chk("rst_mosi", oled_mosi, 0);
    chk("rst_cs_n", oled_cs_n, 1);
    chk("rst_dc", oled_dc, 0);
    chk("rst_busy", txif.send_busy, 0);
    chk("rst_res", oled_res, 0);
    rst = 1'b0;
    step();
    chk("res_follow0", oled_res, 1);

    // Panel reset follows state_rst one cycle later
    for (int i = 0; i < 8; i++) begin
      c = 1'($urandom_range(0, 1));
      state_rst = c;
      step();
      chk("res_follow", oled_res, c);
    end
    state_rst = 1'b1;
    step();

    // Command 0xAE
    xfer(1'b0, 8'hAE, 1, -1);
    step();

    // Data 0xFF, send_en held for 3 cycles: one transfer only
    xfer(1'b1, 8'hFF, 3, -1);
    repeat (3) begin
      step();
      chk("no_second_busy", txif.send_busy, 0);
      chk("no_second_cs", oled_cs_n, 1);
    end

`ifdef OLED_SPI_3WIRE_EN
    xfer(1'b1, 8'h81, 1, -1);
    step();
`endif

    // Request pulse in the middle of a transfer is ignored
    xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1, 40);
    step();

    // Reset at the 4th SCLK rise aborts the transfer
    txif.send_en = 1'b1;
    txif.send_dc = 1'b1;
    txif.send_data = 8'h5A;
    prev_sclk = oled_sclk;
    step();
    txif.send_en = 1'b0;
    rises = 0;
    for (int k = 0; k < LIMIT && rises < 4; k++) begin
      if (oled_sclk && !prev_sclk) rises++;
      prev_sclk = oled_sclk;
      if (rises < 4) step();
    end
    chk("abort_reached", rises, 4);
    rst = 1'b1;
    step();
    chk("abort_cs_n", oled_cs_n, 1);
    chk("abort_sclk", oled_sclk, 0);
    chk("abort_busy", txif.send_busy, 0);
    chk("abort_mosi", oled_mosi, 0);
    chk("abort_dc", oled_dc, 0);
    rst = 1'b0;
    repeat (3) begin
      step();
      chk("abort_no_resume", txif.send_busy, 0);
    end
    xfer(1'b0, 8'hC3, 1, -1);

    // 27 back-to-back random commands/data
    xfers = 0;
    for (int i = 0; i < 27; i++) begin
      d = 8'($urandom_range(0, 255));
      c = 1'($urandom_range(0, 1));
      xfer(c, d, 1, -1);
    end
    chk("b2b_count", xfers, 27);

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog: the bench must always reach its summary line.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
